// File: rtl/mux_tree_cfgchain_array.sv
// mux_tree_cfgchain_array
// An array of N_CH routing mux trees. Select bits are shifted in through a
// serial configuration chain and become live only at a valid commit. A commit
// copies the chain into a shadow register, so the outputs hold steady while
// the chain is reloading. Chains to neighbouring tiles via ccff_head/ccff_tail.
module mux_tree_cfgchain_array #(
    parameter int N_IN      = 6,
    parameter int WIDTH     = 1,
    parameter int N_CH      = 2,
    parameter int CONST_PAD = 1,
    parameter bit PAD_VAL   = 1'b1
) (
    input  logic                        prog_clk,
    input  logic                        pReset,
    input  logic [N_CH*N_IN*WIDTH-1:0]  in,
    input  logic                        cfg_en,
    input  logic                        ccff_head,
    input  logic                        cfg_commit,
    output logic                        ccff_tail,
    output logic [N_CH*WIDTH-1:0]       out,
    output logic                        cfg_done,
    output logic                        cfg_err
);

    localparam int L   = $clog2(N_IN + CONST_PAD);
    localparam int LEN = N_CH * L;
    localparam int CW  = $clog2(LEN + 2);

    localparam logic [CW-1:0] CNT_LEN  = CW'(LEN);
    localparam logic [CW-1:0] CNT_SAT  = CW'(LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_LOADING,
        ST_LOADED,
        ST_OVER
    } state_t;

    state_t          state_q, state_d;
    logic [LEN-1:0]  chain_q, chain_d;
    logic [LEN-1:0]  shadow_q, shadow_d;
    logic [CW-1:0]   count_q, count_d;
    logic            cfg_done_q, cfg_done_d;
    logic            cfg_err_q, cfg_err_d;
    logic            commit_ok;

    // Chain shift, commit qualification, bit counter and load-state transitions
    always_comb begin
        chain_d    = chain_q;
        shadow_d   = shadow_q;
        count_d    = count_q;
        state_d    = state_q;
        cfg_done_d = cfg_done_q;
        cfg_err_d  = cfg_err_q;
        commit_ok  = cfg_commit && (state_q == ST_LOADED);

        if (cfg_en) begin
            chain_d[0] = ccff_head;
            for (int unsigned k = 1; k < LEN; k++) begin
                chain_d[k] = chain_q[k-1];
            end
        end

        // A commit judges the pre-shift chain/count; a same-cycle shift then
        // starts the next load from a count of one.
        if (cfg_commit) begin
            if (commit_ok) begin
                shadow_d   = chain_q;
                cfg_done_d = 1'b1;
            end else begin
                cfg_err_d  = 1'b1;
            end
            count_d = cfg_en ? CW'(1) : '0;
            if (!cfg_en) begin
                state_d = ST_EMPTY;
            end else if (LEN == 1) begin
                state_d = ST_LOADED;
            end else begin
                state_d = ST_LOADING;
            end
        end else if (cfg_en) begin
            if (count_q != CNT_SAT) begin
                count_d = count_q + CW'(1);
            end
            case (state_q)
                ST_EMPTY:   state_d = (LEN == 1) ? ST_LOADED : ST_LOADING;
                ST_LOADING: state_d = (count_q == CNT_LAST) ? ST_LOADED : ST_LOADING;
                ST_LOADED:  state_d = ST_OVER;
                ST_OVER:    state_d = ST_OVER;
                default:    state_d = ST_EMPTY;
            endcase
        end
    end

    // Configuration registers with synchronous reset
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_q    <= ST_EMPTY;
            chain_q    <= '0;
            shadow_q   <= '0;
            count_q    <= '0;
            cfg_done_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            chain_q    <= chain_d;
            shadow_q   <= shadow_d;
            count_q    <= count_d;
            cfg_done_q <= cfg_done_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    logic [L-1:0] sel_n;
    int unsigned  idx;

    // Per-channel mux tree: inverted select picks the leaf, unused leaves drive the pad
    always_comb begin
        out   = '0;
        sel_n = '0;
        idx   = 0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            sel_n = ~shadow_q[c*L +: L];
            idx   = 32'(sel_n);
            if (idx < N_IN) begin
                out[c*WIDTH +: WIDTH] = in[(c*N_IN + idx)*WIDTH +: WIDTH];
            end else begin
                out[c*WIDTH +: WIDTH] = {WIDTH{PAD_VAL}};
            end
        end
    end

    assign ccff_tail = chain_q[LEN-1];
    assign cfg_done  = cfg_done_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_mux_tree_cfgchain_array.sv
// Directed bench for mux_tree_cfgchain_array at N_IN=6, WIDTH=1, N_CH=2,
// CONST_PAD=1, PAD_VAL=1 (three select bits per channel, six-bit chain).
module tb_mux_tree_cfgchain_array;

    logic        prog_clk = 1'b0;
    logic        pReset;
    logic [11:0] in;
    logic        cfg_en;
    logic        ccff_head;
    logic        cfg_commit;
    logic        ccff_tail;
    logic [1:0]  out;
    logic        cfg_done;
    logic        cfg_err;

    int checks   = 0;
    int failures = 0;

    mux_tree_cfgchain_array #(
        .N_IN(6),
        .WIDTH(1),
        .N_CH(2),
        .CONST_PAD(1),
        .PAD_VAL(1'b1)
    ) dut (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .in        (in),
        .cfg_en    (cfg_en),
        .ccff_head (ccff_head),
        .cfg_commit(cfg_commit),
        .ccff_tail (ccff_tail),
        .out       (out),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic shift_one(input logic b);
        cfg_en    = 1'b1;
        ccff_head = b;
        tick();
        cfg_en    = 1'b0;
        ccff_head = 1'b0;
    endtask

    // Shifts val[5] first so the chain ends up holding exactly val
    task automatic load_chain(input logic [5:0] val);
        for (int k = 5; k >= 0; k--) shift_one(val[k]);
    endtask

    task automatic commit_now();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
    endtask

    task automatic do_reset();
        pReset = 1'b1;
        tick();
        pReset = 1'b0;
    endtask

    task automatic test_reset();
        in = '0;
        do_reset();
        checks++; if (out !== 2'b11) begin failures++; $display("FAIL reset_out: got %b expected %b", out, 2'b11); end
        checks++; if (cfg_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", cfg_done); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", cfg_err); end
        checks++; if (ccff_tail !== 1'b0) begin failures++; $display("FAIL reset_tail: got %b expected 0", ccff_tail); end
    endtask

    // ch0 sram=110 (idx1), ch1 sram=011 (idx4)
    task automatic test_load_commit();
        load_chain(6'b011_110);
        in = {6'b101111, 6'b111101};
        #1;
        checks++; if (out !== 2'b11) begin failures++; $display("FAIL shift_no_effect: got %b expected %b", out, 2'b11); end
        in = {6'b010000, 6'b000010};
        commit_now();
        checks++; if (out !== 2'b11) begin failures++; $display("FAIL commit_out_sel: got %b expected %b", out, 2'b11); end
        checks++; if (cfg_done !== 1'b1) begin failures++; $display("FAIL commit_done: got %b expected 1", cfg_done); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL commit_err: got %b expected 0", cfg_err); end
        in = {6'b101111, 6'b111101};
        #1;
        checks++; if (out !== 2'b00) begin failures++; $display("FAIL commit_out_inv: got %b expected %b", out, 2'b00); end
    endtask

    task automatic test_short_commit();
        for (int k = 0; k < 5; k++) shift_one(1'b1);
        commit_now();
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL short_err: got %b expected 1", cfg_err); end
        checks++; if (out !== 2'b00) begin failures++; $display("FAIL short_out_held: got %b expected %b", out, 2'b00); end
        checks++; if (cfg_done !== 1'b1) begin failures++; $display("FAIL short_done: got %b expected 1", cfg_done); end
        // ch0 sram=000 (pad), ch1 sram=111 (idx0)
        in = {6'b111110, 6'b111101};
        #1;
        checks++; if (out !== 2'b10) begin failures++; $display("FAIL short_old_map: got %b expected %b", out, 2'b10); end
        load_chain(6'b111_000);
        commit_now();
        checks++; if (out !== 2'b01) begin failures++; $display("FAIL reload_out: got %b expected %b", out, 2'b01); end
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL reload_err_sticky: got %b expected 1", cfg_err); end
    endtask

    task automatic test_over_commit();
        do_reset();
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL over_pre_err: got %b expected 0", cfg_err); end
        in = {6'b101111, 6'b111101};
        load_chain(6'b011_110);
        commit_now();
        checks++; if (out !== 2'b00) begin failures++; $display("FAIL over_base_out: got %b expected %b", out, 2'b00); end
        for (int k = 0; k < 7; k++) shift_one(1'b1);
        commit_now();
        checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL over_err: got %b expected 1", cfg_err); end
        checks++; if (out !== 2'b00) begin failures++; $display("FAIL over_out_held: got %b expected %b", out, 2'b00); end
        checks++; if (cfg_done !== 1'b1) begin failures++; $display("FAIL over_done: got %b expected 1", cfg_done); end
    endtask

    task automatic test_shift_no_commit();
        logic [5:0] nv;
        logic       exp_tail [6];
        nv = 6'b100001;
        exp_tail = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        load_chain(6'b011_110);
        commit_now();
        checks++; if (ccff_tail !== 1'b0) begin failures++; $display("FAIL replay_tail_0: got %b expected 0", ccff_tail); end
        for (int k = 0; k < 6; k++) begin
            shift_one(nv[5-k]);
            checks++; if (ccff_tail !== exp_tail[k]) begin failures++; $display("FAIL replay_tail_%0d: got %b expected %b", k+1, ccff_tail, exp_tail[k]); end
            checks++; if (out !== 2'b00) begin failures++; $display("FAIL replay_out_%0d: got %b expected %b", k+1, out, 2'b00); end
        end
    endtask

    task automatic test_back_to_back();
        in = '0;
        #1;
        // commit 100001 while shifting in the first bit (0) of the next load
        cfg_en     = 1'b1;
        ccff_head  = 1'b0;
        cfg_commit = 1'b1;
        tick();
        cfg_en     = 1'b0;
        cfg_commit = 1'b0;
        checks++; if (out !== 2'b01) begin failures++; $display("FAIL b2b_pre_shift: got %b expected %b", out, 2'b01); end
        // five more bits complete 000111 only if the counter restarted at one
        shift_one(1'b0);
        shift_one(1'b0);
        shift_one(1'b1);
        shift_one(1'b1);
        shift_one(1'b1);
        commit_now();
        checks++; if (out !== 2'b10) begin failures++; $display("FAIL b2b_count1: got %b expected %b", out, 2'b10); end
        shift_one(1'b1);
        shift_one(1'b1);
        pReset    = 1'b1;
        cfg_en    = 1'b1;
        ccff_head = 1'b1;
        tick();
        pReset    = 1'b0;
        cfg_en    = 1'b0;
        ccff_head = 1'b0;
        checks++; if (out !== 2'b11) begin failures++; $display("FAIL midrst_out: got %b expected %b", out, 2'b11); end
        checks++; if (cfg_done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b expected 0", cfg_done); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL midrst_err: got %b expected 0", cfg_err); end
        checks++; if (ccff_tail !== 1'b0) begin failures++; $display("FAIL midrst_tail: got %b expected 0", ccff_tail); end
    endtask

    initial begin
        pReset     = 1'b1;
        in         = '0;
        cfg_en     = 1'b0;
        ccff_head  = 1'b0;
        cfg_commit = 1'b0;
        tick();
        test_reset();
        test_load_commit();
        test_short_commit();
        test_over_commit();
        test_shift_no_commit();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
